mul_seq: RTL

Operand sequencer that sits directly upstream of the 4x4 shift-add multiplier. Buffers incoming operand pairs in a small FIFO and drives each pair into the multiplier with a start handshake. Detects completion from the multiplier's `fin` and returns the 8-bit product through a valid/ready output port. Serialises back-to-back requests so the multiplier only ever sees one operation at a time.

---
 rtl/mul_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - operand FIFO and start/fin sequencer in front of a 4x4 shift-add multiplier
// Optional watchdog: define MUL_SEQ_TIMEOUT_EN.
// Ports:
//   clk, n_rst                                   clock, asynchronous active-low reset
//   in_valid, in_ready, in_a, in_b               operand pair push port
//   mul_multiplier, mul_multiplicand, mul_start  operands and start to the multiplier
//   mul_fin, mul_product                         multiplier done level and result
//   out_valid, out_ready, out_product            result port
//   level                                        FIFO occupancy
//   err                                          sticky watchdog flag (0 without the watchdog)
module mul_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_a,
  input  logic [3:0]              in_b,
  output logic [3:0]              mul_multiplier,
  output logic [3:0]              mul_multiplicand,
  output logic                    mul_start,
  input  logic                    mul_fin,
  input  logic [7:0]              mul_product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_product,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255)
  begin : g_bad_param
    $error("mul_seq: DEPTH must be a power of two in 2..16 and TIMEOUT in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [7:0]     fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  count_q;
  logic           push, pop, capture;
  logic           full;
  logic           fin_q, fin_rise;
  logic           wd_expired;
  logic [3:0]     a_q, b_q;
  logic [7:0]     prod_q;

  // A push while full is refused even when a pop happens in the same
  // cycle, so in_ready depends on occupancy alone.
  assign full     = (count_q == LW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign level    = count_q;

  // Only a 0->1 edge counts, so a fin left high from a previous
  // operation cannot complete the next one.
  assign fin_rise = mul_fin && !fin_q;

  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign mul_start        = (state_q == S_RUN);
  assign out_valid        = (state_q == S_HOLD);
  assign out_product      = prod_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (fin_rise) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else if (wd_expired) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      fin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      fin_q   <= mul_fin;
      if (pop)     {a_q, b_q} <= fifo_mem[rd_ptr];
      if (capture) prod_q     <= mul_product;
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  // wd_cnt holds the number of completed RUN cycles, so the expiry
  // decision in the TIMEOUT-th RUN cycle compares against TIMEOUT-1.
  assign wd_expired = (wd_cnt == 8'(TIMEOUT - 1));
  assign err        = err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_LOAD)     wd_cnt <= '0;
      else if (state_q == S_RUN) wd_cnt <= wd_cnt + 8'd1;
      if (state_q == S_RUN && !fin_rise && wd_expired) err_q <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
